// File: rtl/rs_pkg.sv
// Shared GF(2^m) arithmetic, encoder state encoding and default field/code
// constants for the Reed-Solomon stream encoder.
package rs_pkg;

   localparam int              RS_SYMBOL_WIDTH = 3;
   localparam int              RS_N            = 7;
   localparam int              RS_K            = 5;
   localparam logic [3:0]      RS_PRIM_POLY    = 4'b1011;
   localparam logic [5:0]      RS_GEN_POLY     = 6'b110_011;

   // Widest symbol the shared multiplier can handle.
   localparam int              GF_MAX_W        = 16;

   typedef enum logic [0:0] {
      ST_MSG = 1'b0,
      ST_PAR = 1'b1
   } rs_state_e;

   // Shift-and-add multiply of a by b, reducing by poly whenever bit m appears.
   // Operands and poly are zero-extended to GF_MAX_W; the result stays below 2^m.
   function automatic logic [GF_MAX_W-1:0] gf_mul(
      input logic [GF_MAX_W-1:0] a,
      input logic [GF_MAX_W-1:0] b,
      input logic [GF_MAX_W:0]   poly,
      input int                  m
   );
      logic [GF_MAX_W:0]   acc_a;
      logic [GF_MAX_W-1:0] prod;
      prod  = {GF_MAX_W{1'b0}};
      acc_a = {1'b0, a};
      for (int i = 0; i < GF_MAX_W; i++) begin
         if (i < m) begin
            if (b[i]) begin
               prod = prod ^ acc_a[GF_MAX_W-1:0];
            end else begin
               prod = prod;
            end
            acc_a = acc_a << 1;
            if (acc_a[m]) begin
               acc_a = acc_a ^ poly;
            end else begin
               acc_a = acc_a;
            end
         end else begin
            prod = prod;
         end
      end
      return prod;
   endfunction

endpackage

// File: rtl/rs_gf_mult.sv
// Combinational GF(2^m) multiplier, one instance per generator tap.
module rs_gf_mult
   import rs_pkg::*;
#(
   parameter int                    SYMBOL_WIDTH = RS_SYMBOL_WIDTH,
   parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = RS_PRIM_POLY
) (
   input  logic [SYMBOL_WIDTH-1:0] a,
   input  logic [SYMBOL_WIDTH-1:0] b,
   output logic [SYMBOL_WIDTH-1:0] p
);

   if (SYMBOL_WIDTH < 1 || SYMBOL_WIDTH > GF_MAX_W) begin : g_bad_width
      $error("rs_gf_mult: SYMBOL_WIDTH out of supported range");
   end

   // Product reduced by the field polynomial, truncated back to symbol width.
   assign p = SYMBOL_WIDTH'(gf_mul(GF_MAX_W'(a), GF_MAX_W'(b),
                                   (GF_MAX_W+1)'(PRIM_POLY), SYMBOL_WIDTH));

endmodule

// File: rtl/rs_stream_encoder.sv
// Systematic Reed-Solomon stream encoder with valid/ready handshakes on both sides.
// Optional RS_SHORTEN_EN adds in_last to end a message early (shortened code).
module rs_stream_encoder
   import rs_pkg::*;
#(
   parameter int                                  SYMBOL_WIDTH = RS_SYMBOL_WIDTH,
   parameter int                                  N            = RS_N,
   parameter int                                  K            = RS_K,
   parameter logic [SYMBOL_WIDTH:0]               PRIM_POLY    = RS_PRIM_POLY,
   parameter logic [(N-K)*SYMBOL_WIDTH-1:0]       GEN_POLY     = RS_GEN_POLY
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
`ifdef RS_SHORTEN_EN
   input  logic                    in_last,
`endif
   input  logic [SYMBOL_WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SYMBOL_WIDTH-1:0] out_data,
   output logic                    out_sop,
   output logic                    out_eop,
   output logic                    out_parity
);

   localparam int NK  = N - K;
   localparam int MCW = (K > 1)  ? $clog2(K)  : 1;
   localparam int PCW = (NK > 1) ? $clog2(NK) : 1;

   if (NK < 1 || K < 1) begin : g_bad_code
      $error("rs_stream_encoder: need N-K >= 1 and K >= 1");
   end

   rs_state_e                        state_r, state_nx_s;
   logic [NK-1:0][SYMBOL_WIDTH-1:0]  lfsr_r, lfsr_nx_s, tap_s;
   logic [MCW-1:0]                   msg_cnt_r, msg_cnt_nx_s;
   logic [PCW-1:0]                   par_cnt_r, par_cnt_nx_s;
   logic [SYMBOL_WIDTH-1:0]          fb_s;
   logic                             load_en_s, msg_hs_s, last_msg_s, last_par_s;
   logic                             out_valid_r, out_valid_nx_s;
   logic [SYMBOL_WIDTH-1:0]          out_data_r, out_data_nx_s;
   logic                             out_sop_r, out_sop_nx_s;
   logic                             out_eop_r, out_eop_nx_s;
   logic                             out_parity_r, out_parity_nx_s;

   assign load_en_s  = !out_valid_r || out_ready;
   assign in_ready   = (state_r == ST_MSG) && load_en_s;
   assign msg_hs_s   = in_valid && in_ready;
   assign fb_s       = in_data ^ lfsr_r[NK-1];
   assign last_par_s = (par_cnt_r == PCW'(NK-1));
`ifdef RS_SHORTEN_EN
   assign last_msg_s = (msg_cnt_r == MCW'(K-1)) || in_last;
`else
   assign last_msg_s = (msg_cnt_r == MCW'(K-1));
`endif

   for (genvar i = 0; i < NK; i++) begin : g_tap
      rs_gf_mult #(
         .SYMBOL_WIDTH (SYMBOL_WIDTH),
         .PRIM_POLY    (PRIM_POLY)
      ) u_mult (
         .a (fb_s),
         .b (GEN_POLY[i*SYMBOL_WIDTH +: SYMBOL_WIDTH]),
         .p (tap_s[i])
      );
   end

   assign out_valid  = out_valid_r;
   assign out_data   = out_data_r;
   assign out_sop    = out_sop_r;
   assign out_eop    = out_eop_r;
   assign out_parity = out_parity_r;

   // Next-state, LFSR, counters and output-register contents.
   always_comb begin
      state_nx_s      = state_r;
      lfsr_nx_s       = lfsr_r;
      msg_cnt_nx_s    = msg_cnt_r;
      par_cnt_nx_s    = par_cnt_r;
      out_valid_nx_s  = out_valid_r;
      out_data_nx_s   = out_data_r;
      out_sop_nx_s    = out_sop_r;
      out_eop_nx_s    = out_eop_r;
      out_parity_nx_s = out_parity_r;
      case (state_r)
         ST_MSG: begin
            if (load_en_s) begin
               out_valid_nx_s  = msg_hs_s;
               out_data_nx_s   = in_data;
               out_sop_nx_s    = msg_hs_s && (msg_cnt_r == '0);
               out_eop_nx_s    = 1'b0;
               out_parity_nx_s = 1'b0;
            end else begin
               out_valid_nx_s  = out_valid_r;
            end
            if (msg_hs_s) begin
               lfsr_nx_s = (lfsr_r << SYMBOL_WIDTH) ^ tap_s;
               if (last_msg_s) begin
                  msg_cnt_nx_s = '0;
                  state_nx_s   = ST_PAR;
               end else begin
                  msg_cnt_nx_s = msg_cnt_r + MCW'(1);
               end
            end else begin
               lfsr_nx_s = lfsr_r;
            end
         end
         ST_PAR: begin
            if (load_en_s) begin
               out_valid_nx_s  = 1'b1;
               out_data_nx_s   = lfsr_r[NK-1];
               out_sop_nx_s    = 1'b0;
               out_parity_nx_s = 1'b1;
               out_eop_nx_s    = last_par_s;
               // Last parity frees the encoder so the next message lands without a bubble.
               if (last_par_s) begin
                  lfsr_nx_s    = '0;
                  par_cnt_nx_s = '0;
                  state_nx_s   = ST_MSG;
               end else begin
                  lfsr_nx_s    = lfsr_r << SYMBOL_WIDTH;
                  par_cnt_nx_s = par_cnt_r + PCW'(1);
               end
            end else begin
               out_valid_nx_s = out_valid_r;
            end
         end
         default: begin
            state_nx_s = ST_MSG;
         end
      endcase
   end

   // State, LFSR, counters and the single output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_MSG;
         lfsr_r       <= '0;
         msg_cnt_r    <= '0;
         par_cnt_r    <= '0;
         out_valid_r  <= 1'b0;
         out_data_r   <= '0;
         out_sop_r    <= 1'b0;
         out_eop_r    <= 1'b0;
         out_parity_r <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         lfsr_r       <= lfsr_nx_s;
         msg_cnt_r    <= msg_cnt_nx_s;
         par_cnt_r    <= par_cnt_nx_s;
         out_valid_r  <= out_valid_nx_s;
         out_data_r   <= out_data_nx_s;
         out_sop_r    <= out_sop_nx_s;
         out_eop_r    <= out_eop_nx_s;
         out_parity_r <= out_parity_nx_s;
      end
   end

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Directed bench for rs_stream_encoder with default RS(7,5) over GF(8);
// the shortened-code case runs only when RS_SHORTEN_EN is defined.
module tb_rs_stream_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
`ifdef RS_SHORTEN_EN
   logic       in_last;
`endif
   logic [2:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_data;
   logic       out_sop;
   logic       out_eop;
   logic       out_parity;

   int         total = 0;
   int         bad   = 0;
   int         n_valid, first_v, last_v, n_irdy_low;
   logic [5:0] out_q[$];
   int         msg_q[$];
   int         exp_q[$];

   always #5 clk = ~clk;

   rs_stream_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
`ifdef RS_SHORTEN_EN
      .in_last    (in_last),
`endif
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_parity (out_parity)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Feed msg, drain n_exp output symbols as {sop,eop,parity,data}; bp=1 randomises out_ready.
   task automatic run(input int msg[$], input int last_idx, input int bp, input int n_exp);
      int         idx  = 0;
      int         cyc  = 0;
      logic       hold = 1'b0;
      logic [2:0] held = 3'd0;
      out_q.delete();
      n_valid = 0; first_v = -1; last_v = -1; n_irdy_low = 0;
      while (out_q.size() < n_exp && cyc < 300) begin
         @(negedge clk);
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid  = (idx < msg.size());
         if (in_valid) in_data = 3'(msg[idx]);
         else          in_data = 3'd0;
`ifdef RS_SHORTEN_EN
         in_last   = (idx == last_idx);
`endif
         #1;
         if (hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(held));
         end
         hold = out_valid && !out_ready;
         held = out_data;
         if (!in_ready) n_irdy_low++;
         if (out_valid) begin
            n_valid++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
         end
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) out_q.push_back({out_sop, out_eop, out_parity, out_data});
         cyc++;
      end
      chk("timeout", 32'(out_q.size()), 32'(n_exp));
      in_valid = 1'b0;
`ifdef RS_SHORTEN_EN
      in_last  = 1'b0;
`endif
      if (last_idx == -2) chk("last_idx", 32'(last_idx), 32'd0);
   endtask

   // Compare drained symbols against expected data; codewords are mlen msg + 2 parity.
   task automatic verify(input int exp[$], input int mlen, input string tag);
      logic [5:0] e;
      int         p;
      for (int i = 0; i < exp.size(); i++) begin
         p = i % (mlen + 2);
         e = {(p == 0), (p == mlen + 1), (p >= mlen), 3'(exp[i])};
         if (i < out_q.size()) chk(tag, 32'(out_q[i]), 32'(e));
         else                  chk(tag, 32'd99, 32'(e));
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 3'd0;
      out_ready = 1'b1;
`ifdef RS_SHORTEN_EN
      in_last   = 1'b0;
`endif
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out", 32'({out_valid, out_sop, out_eop, out_parity, out_data}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      msg_q = {0, 0, 0, 0, 0};  exp_q = {0, 0, 0, 0, 0, 0, 0};
      run(msg_q, -1, 0, 7);     verify(exp_q, 5, "zero");

      msg_q = {1, 0, 0, 0, 0};  exp_q = {1, 0, 0, 0, 0, 6, 2};
      run(msg_q, -1, 0, 7);     verify(exp_q, 5, "impulse");

      msg_q = {0, 0, 0, 0, 1};  exp_q = {0, 0, 0, 0, 1, 6, 3};
      run(msg_q, -1, 0, 7);     verify(exp_q, 5, "low_sym");

      msg_q = {0, 0, 0, 1, 0};  exp_q = {0, 0, 0, 1, 0, 1, 1};
      run(msg_q, -1, 0, 7);     verify(exp_q, 5, "x3_sym");

      msg_q = {1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      exp_q = {1, 0, 0, 0, 0, 6, 2, 0, 0, 0, 1, 0, 1, 1};
      run(msg_q, -1, 0, 14);    verify(exp_q, 5, "b2b");
      chk("b2b_valid", 32'(n_valid), 32'd14);
      chk("b2b_span", 32'(last_v - first_v + 1), 32'd14);
      chk("b2b_irdy_low", 32'(n_irdy_low), 32'd4);

      msg_q = {1, 0, 0, 0, 0};  exp_q = {1, 0, 0, 0, 0, 6, 2};
      run(msg_q, -1, 1, 7);     verify(exp_q, 5, "bp");

      msg_q = {1, 0, 0};
      run(msg_q, -1, 0, 3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_out", 32'({out_valid, out_sop, out_eop, out_parity, out_data}), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("mid_rst_hold", 32'({out_valid, out_sop, out_eop, out_parity, out_data}), 32'd0);
      rst = 1'b0;
      msg_q = {1, 0, 0, 0, 0};  exp_q = {1, 0, 0, 0, 0, 6, 2};
      run(msg_q, -1, 0, 7);     verify(exp_q, 5, "post_rst");

`ifdef RS_SHORTEN_EN
      msg_q = {1};              exp_q = {1, 6, 3};
      run(msg_q, 0, 0, 3);      verify(exp_q, 1, "short");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
